spi_cmd_master: RTL
===================

# spi_cmd_master

SPI command master that drives the serial side of the SPI-slave/RAM subsystem. It accepts a 2-bit command plus 8-bit payload from a host-side handshake and serialises it as one SPI frame on MOSI/SS_n. For read-data frames it also captures the 8-bit response on MISO and returns it to the host. All logic runs in the same clock domain as the slave it drives.

## Interface

- READ_GAP, 2: cycles between the last command bit and the first MISO sample on read-data frames; legal range 0..15.
- IDLE_GAP, 1: minimum SS_n-high cycles between frames; legal range 1..15.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  host request; accepted on a rising edge where start=1 and ready=1.
- cmd  in  2  command: 00 write address, 01 write data, 10 read address, 11 read data.
- payload  in  8  address or data byte; ignored as data for cmd=11, but still shifted out.
- ready  out  1  high only in IDLE; new request may be accepted.
- done  out  1  one-cycle pulse at end of every frame.
- rd_data  out  8  byte captured on MISO; updated only at the end of cmd=11 frames.
- MOSI  out  1  serial data to slave, MSB first.
- MISO  in  1  serial data from slave.
- SS_n  out  1  slave select, active low.

## Operation

- States: IDLE, PRE, SHIFT, GAP, RECV, END.
- Reset (async, immediate): state=IDLE, SS_n=1, MOSI=0, done=0, rd_data=8'h00, all counters=0, ready=1 once rst deasserts.
- IDLE: SS_n=1, MOSI=0. On start&ready: latch frame={cmd,payload} (10 bits), go PRE. start with ready=0 is ignored, with no queueing.
- PRE (1 cycle): SS_n=0, MOSI=cmd[1] (read/write selector bit). Go SHIFT.
- SHIFT (10 cycles): SS_n=0, MOSI=frame[9] down to frame[0], one bit per cycle. After the last bit: go GAP if cmd=11, else END.
- GAP (READ_GAP cycles; skipped if 0): SS_n=0, MOSI=0.
- RECV (8 cycles): SS_n=0, MOSI=0. MISO is sampled at the rising edge ending each cycle and shifted in MSB first. After the 8th sample, the shift register is copied to rd_data. Go END.
- END (IDLE_GAP cycles): SS_n=1, MOSI=0. done=1 in the first END cycle only. Then go IDLE.
- Latched cmd/payload are immune to input changes mid-frame.
- rd_data holds its value across non-read frames.

## Timing

- Edge E0 accepts the request. The PRE cycle follows E0, so SS_n falls one cycle after acceptance.
- SS_n-low duration:
  - cmd 00/01/10: exactly 11 cycles.
  - cmd 11: 11+READ_GAP+8 cycles (21 at defaults).
- Latency, E0 to done high:
  - cmd 00/01/10: 11 cycles (done high in cycle 12).
  - cmd 11: 19+READ_GAP cycles.
- rd_data is valid in the same cycle done rises.
- ready returns high IDLE_GAP cycles after done rises. Back-to-back frames with start held high: SS_n high for exactly IDLE_GAP+1 cycles (END plus the IDLE acceptance cycle).
- MOSI changes only on rising edges. The slave samples on the following edge.
- rst asserted mid-frame: SS_n=1 and MOSI=0 immediately, done is not pulsed, partial MISO data is discarded, rd_data=0. After release, ready=1 in the first cycle.

## Test plan

- Write address: cmd=00, payload=8'h3A. Required: MOSI over the 11 SS_n-low cycles = 0,0,0,0,0,1,1,1,0,1,0. SS_n low for 11 cycles. done pulses once. rd_data unchanged.
- Read data: cmd=11, with a bench slave model driving 8'hA5 on MISO starting READ_GAP cycles after the last command bit. Required: MOSI = 1,1,1, then the payload bits. rd_data=8'hA5 with done. SS_n low for 21 cycles at defaults.
- Full transaction: write addr 8'h10, write data 8'hC3, read addr 8'h10, read data, against the SPI-slave/RAM wrapper. Required: rd_data=8'hC3.
- Busy rejection: pulse start with cmd=01 at cycle 5 of an ongoing frame. Required: it is ignored, exactly one done pulse occurs, and the MOSI pattern is unchanged.
- Back-to-back: start held high with IDLE_GAP=3. Required: SS_n high for exactly 4 cycles between frames, and one done pulse per frame.
- Reset mid-frame: assert rst during RECV. Required: SS_n=1, MOSI=0, and rd_data=0 in the same cycle. No done pulse. ready=1 after rst release, and the next frame is correct.

Source files
------------

// File: rtl/spi_cmd_master_if.sv
// Host-side request/response bundle for spi_cmd_master.
//   start   : host request, accepted when ready is high
//   cmd     : 2-bit command (00 wr addr, 01 wr data, 10 rd addr, 11 rd data)
//   payload : address or data byte shifted out after the command
//   ready   : master idle, a request may be accepted
//   done    : one-cycle pulse at the end of every frame
//   rd_data : byte captured on MISO by the last read-data frame
// master modport = host side, slave modport = spi_cmd_master side.
interface spi_cmd_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] payload;
  logic       ready;
  logic       done;
  logic [7:0] rd_data;

  modport master (output start, cmd, payload, input ready, done, rd_data);
  modport slave  (input start, cmd, payload, output ready, done, rd_data);
endinterface

// File: rtl/spi_cmd_master.sv
// SPI command master: serialises {cmd, payload} as one SS_n-framed burst on
// MOSI and, for read-data commands, captures an 8-bit MISO response.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   host     : request/response bundle (slave modport of spi_cmd_master_if)
//   MOSI     : serial data out, MSB first, changes on rising edges
//   MISO     : serial data in, sampled on the rising edge ending each RECV cycle
//   SS_n     : slave select, active low
// Parameters:
//   READ_GAP : cycles between last command bit and first MISO sample (0..15)
//   IDLE_GAP : minimum SS_n-high cycles between frames (1..15)
module spi_cmd_master #(
  parameter int unsigned READ_GAP = 2,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_cmd_master_if.slave         host,
  output logic                    MOSI,
  input  logic                    MISO,
  output logic                    SS_n
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SHIFT,
    S_GAP,
    S_RECV,
    S_END
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  frame;    // outgoing bits, consumed from the top
  logic                is_read;  // frame is a read-data command
  logic [DATA_W-1:0]   rx;
  logic [CNT_W-1:0]    cnt;

  // Single-process FSM; every output is a register updated on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      frame        <= '0;
      is_read      <= 1'b0;
      rx           <= '0;
      cnt          <= '0;
      SS_n         <= 1'b1;
      MOSI         <= 1'b0;
      host.ready   <= 1'b1;
      host.done    <= 1'b0;
      host.rd_data <= '0;
    end else begin
      host.done <= 1'b0;
      case (state)
        S_IDLE: begin
          // ready is high throughout IDLE, so start alone means acceptance
          if (host.start) begin
            frame      <= {host.cmd, host.payload};
            is_read    <= (host.cmd == 2'b11);
            state      <= S_PRE;
            SS_n       <= 1'b0;
            MOSI       <= host.cmd[1];
            host.ready <= 1'b0;
          end
        end

        S_PRE: begin
          state <= S_SHIFT;
          MOSI  <= frame[FRAME_W-1];
          frame <= {frame[FRAME_W-2:0], 1'b0};
          cnt   <= '0;
        end

        S_SHIFT: begin
          if (cnt == CNT_W'(FRAME_W - 1)) begin
            MOSI <= 1'b0;
            cnt  <= '0;
            if (!is_read) begin
              state     <= S_END;
              SS_n      <= 1'b1;
              host.done <= 1'b1;
            end else if (READ_GAP == 0) begin
              state <= S_RECV;
            end else begin
              state <= S_GAP;
            end
          end else begin
            MOSI  <= frame[FRAME_W-1];
            frame <= {frame[FRAME_W-2:0], 1'b0};
            cnt   <= cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt == CNT_W'(READ_GAP - 1)) begin
            state <= S_RECV;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RECV: begin
          rx <= {rx[DATA_W-2:0], MISO};
          if (cnt == CNT_W'(DATA_W - 1)) begin
            // publish the byte together with done
            host.rd_data <= {rx[DATA_W-2:0], MISO};
            host.done    <= 1'b1;
            state        <= S_END;
            SS_n         <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_END: begin
          if (cnt == CNT_W'(IDLE_GAP - 1)) begin
            state      <= S_IDLE;
            host.ready <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          SS_n       <= 1'b1;
          MOSI       <= 1'b0;
          host.ready <= 1'b1;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule
